// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each held for
// clks_per_bit clocks. One byte is accepted per valid/ready handshake while idle.
`timescale 1ns/1ps
module uart_tx #(
    parameter int clks_per_bit = 543
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(clks_per_bit - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic        serial_q, serial_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic [2:0]  idx_nxt;
    logic        bit_end;

    assign idx_nxt = idx_q + 3'd1;
    assign bit_end = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Serial is computed for the next state so the pad is driven straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                if (i_tx_valid) begin
                    hold_d   = i_tx_byte;
                    cnt_d    = '0;
                    state_d  = START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = DATA;
                    serial_d = hold_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d    = '0;
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        idx_d    = idx_nxt;
                        serial_d = hold_q[idx_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                serial_d = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_tx_ready  = (state_q == IDLE);
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter; the transmit-side counterpart of the team's `uart_rx` receiver.
- Accepts one byte per valid/ready handshake.
- Serialises the byte as: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts `clks_per_bit` clocks.
- Sits between the host-side byte source and the `tx` pad. Uses the same `clks_per_bit` setting as `uart_rx` so the two interoperate on one link.

Parameters:
- clks_per_bit, 543, clock cycles per serial bit (= f_clk / baud); legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- i_tx_valid  input  1  host has a byte to send.
- i_tx_byte  input  8  byte to send; sampled only on accept.
- o_tx_ready  output  1  block can accept a byte (high only in IDLE).
- o_tx_serial  output  1  serial line, registered; idles high.
- o_tx_active  output  1  high while a frame is on the line (START/DATA/STOP).
- o_tx_done  output  1  one-cycle pulse after a frame completes.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - Next state is IDLE.
  - o_tx_serial=1, o_tx_active=0, o_tx_done=0.
  - Internal counter=0, bit_index=0, shift/hold register=0.
  - o_tx_ready=1 from the first cycle after reset.
- Reset mid-frame: the frame is aborted. Line returns high on that edge, no o_tx_done pulse, block is ready the next cycle.
- o_tx_ready = (state==IDLE); decoded directly from the state register.
- Accept: an edge with i_tx_valid=1 and o_tx_ready=1.
  - Latch i_tx_byte into the hold register.
  - Counter=0; state goes to START.
  - o_tx_serial=0 and o_tx_active=1 on that same edge.
- i_tx_valid while not ready is ignored (no queuing). i_tx_byte changes after accept have no effect.
- 16-bit counter. Each bit period is exactly `clks_per_bit` cycles: counter runs 0..clks_per_bit-1, then advances to the next bit and returns to 0.
- States:
  - IDLE: serial=1, active=0. Accept → START.
  - START: serial=0 for clks_per_bit cycles → DATA, bit_index=0.
  - DATA: serial=hold[bit_index] for clks_per_bit cycles per bit.
    - bit_index 0..6: increment and stay in DATA.
    - bit_index 7: go to STOP, bit_index=0.
  - STOP: serial=1 for clks_per_bit cycles, then → IDLE.
    - On that edge: o_tx_done=1, o_tx_active=0.
  - Illegal/default state → IDLE with serial=1.
- o_tx_done is high exactly one cycle (the first IDLE cycle after STOP); cleared on every other edge.
- Timing, with accept at edge E0 and C = clks_per_bit:
  - Start bit is driven on edges E0..E0+C.
  - Data bit n is driven on edges E0+(n+1)C.
  - Stop bit is driven on edge E0+9C.
  - Return to IDLE and the o_tx_done pulse are on edge E0+10C.
- Back-to-back: with i_tx_valid held high, the next accept is at E0+10C+1. The line stays high for exactly 1 cycle between stop and next start; frame period is 10C+1.
- No combinational path from inputs to any output.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_tx_valid=1 → serial=1, ready=1 (after the first post-reset cycle), active=0, done=0 throughout; no accept occurs during reset.
- Single frame, clks_per_bit=4, send 0xA5 → serial = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. Active is high for 40 cycles, then done pulses once, then ready=1.
- Back-to-back, clks_per_bit=4: 0x00 then 0xFF with valid held → second start bit begins 41 cycles after the first. Line is high for exactly 1 cycle between frames. Two done pulses, 41 cycles apart.
- Busy-ignore: accept 0x3C, then pulse valid with 0xFF mid-DATA → the line carries only the 0x3C frame. The 0xFF is never transmitted.
- Reset mid-frame: assert i_rst_n=0 during bit 3 of 0x81 → serial=1 on that edge, no done pulse. After release, sending 0x55 yields a correct full frame.
- Loopback with `uart_rx` at clks_per_bit=543: send 0x00, 0xFF, 0x3C, 0xA5 back-to-back → receiver data-available pulses 4 times with matching bytes. Transmitter done pulses 4 times.
